// File: rtl/mux4_scan_ctrl_pkg.sv
// Shared types and constants for the 4:1 mux scan controller.
package mux4_scan_ctrl_pkg;

  localparam int unsigned MUX_W  = 4;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned WCNT_W = 8;
  localparam int unsigned HOLD_MAX = 16;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_e;

  // Bit a correctly wired mux should present for a given select.
  function automatic logic sel_bit(input logic [MUX_W-1:0] word,
                                   input logic [SEL_W-1:0] sel);
    return word[sel];
  endfunction

endpackage

// File: rtl/mux4_hold_timer.sv
// Hold counter: counts HOLD cycles while enabled and flags the last one.
module mux4_hold_timer #(
  parameter int unsigned HOLD = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc_c
);

  localparam int unsigned CNT_W = (HOLD > 1) ? $clog2(HOLD) : 1;

  logic [CNT_W-1:0] cnt;

  assign tc_c = en && (cnt == CNT_W'(HOLD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      if (tc_c) cnt <= '0;
      else      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mux4_scan_ctrl.sv
// Scans a 4-bit word through an external 4:1 mux one select at a time,
// serialises the mux output and flags any bit that disagrees with the word.
module mux4_scan_ctrl
  import mux4_scan_ctrl_pkg::*;
#(
  parameter int unsigned HOLD = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [MUX_W-1:0]  in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [MUX_W-1:0]  mux_i,
  output logic [SEL_W-1:0]  mux_s,
  input  logic              mux_y,
  output logic              ser_bit,
  output logic              ser_valid,
  output logic              ser_last,
  output logic              err,
  input  logic              err_clr,
  output logic [WCNT_W-1:0] word_cnt
);

  if (HOLD == 0 || HOLD > HOLD_MAX) begin : g_hold_chk
    $error("mux4_scan_ctrl: HOLD must be within 1..16");
  end

  state_e state_q, state_d;

  logic              take;
  logic              tc_c;
  logic              last_sel;
  logic              mismatch;
  logic [MUX_W-1:0]  mux_i_d;
  logic [SEL_W-1:0]  mux_s_d;
  logic              ser_bit_d;
  logic              ser_valid_d;
  logic              ser_last_d;
  logic              err_d;
  logic [WCNT_W-1:0] word_cnt_d;

  assign in_ready = (state_q == ST_IDLE);
  assign take     = in_valid && in_ready;
  assign last_sel = (mux_s == SEL_W'(MUX_W - 1));

  mux4_hold_timer #(.HOLD(HOLD)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (take),
    .en    (state_q == ST_SCAN),
    .tc_c  (tc_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (take)            state_d = ST_SCAN;
      ST_SCAN: if (tc_c && last_sel) state_d = ST_IDLE;
      default:                      state_d = ST_IDLE;
    endcase
  end

  // Datapath next values: load on transfer, sample/advance on terminal count.
  always_comb begin
    mux_i_d     = mux_i;
    mux_s_d     = mux_s;
    ser_bit_d   = ser_bit;
    ser_valid_d = 1'b0;
    ser_last_d  = 1'b0;
    word_cnt_d  = word_cnt;
    mismatch    = 1'b0;
    if (take) begin
      mux_i_d = in_data;
      mux_s_d = '0;
    end
    if (state_q == ST_SCAN && tc_c) begin
      ser_bit_d   = mux_y;
      ser_valid_d = 1'b1;
      mux_s_d     = mux_s + SEL_W'(1);
      mismatch    = (mux_y != sel_bit(mux_i, mux_s));
      if (last_sel) begin
        ser_last_d = 1'b1;
        word_cnt_d = word_cnt + WCNT_W'(1);
      end
    end
    // A fresh mismatch outranks a clear request.
    if (mismatch)     err_d = 1'b1;
    else if (err_clr) err_d = 1'b0;
    else              err_d = err;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mux_i     <= '0;
      mux_s     <= '0;
      ser_bit   <= 1'b0;
      ser_valid <= 1'b0;
      ser_last  <= 1'b0;
      err       <= 1'b0;
      word_cnt  <= '0;
    end else begin
      mux_i     <= mux_i_d;
      mux_s     <= mux_s_d;
      ser_bit   <= ser_bit_d;
      ser_valid <= ser_valid_d;
      ser_last  <= ser_last_d;
      err       <= err_d;
      word_cnt  <= word_cnt_d;
    end
  end

endmodule

// File: tb/tb_mux4_scan_ctrl.sv
// Scoreboard bench for mux4_scan_ctrl with HOLD=1 and HOLD=3 instances.
module tb_mux4_scan_ctrl;

  typedef struct packed {
    logic        b;
    logic        l;
    int unsigned c;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic fault = 1'b0;
  int unsigned cyc = 0;
  int tests = 0;
  int fails = 0;

  logic [3:0] in_data1 = '0, in_data3 = '0;
  logic       in_valid1 = 1'b0, in_valid3 = 1'b0;
  logic       err_clr1 = 1'b0, err_clr3 = 1'b0;
  logic       in_ready1, in_ready3;
  logic [3:0] mux_i1, mux_i3;
  logic [1:0] mux_s1, mux_s3;
  logic       mux_y1, mux_y3;
  logic       ser_bit1, ser_bit3, ser_valid1, ser_valid3, ser_last1, ser_last3;
  logic       err1, err3;
  logic [7:0] word_cnt1, word_cnt3;

  ev_t exp1[$], obs1[$], exp3[$], obs3[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // External structural 4:1 mux; the HOLD=1 one can be stuck at 0.
  assign mux_y1 = fault ? 1'b0 : mux_i1[mux_s1];
  assign mux_y3 = mux_i3[mux_s3];

  mux4_scan_ctrl #(.HOLD(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data1), .in_valid(in_valid1),
    .in_ready(in_ready1), .mux_i(mux_i1), .mux_s(mux_s1), .mux_y(mux_y1),
    .ser_bit(ser_bit1), .ser_valid(ser_valid1), .ser_last(ser_last1),
    .err(err1), .err_clr(err_clr1), .word_cnt(word_cnt1)
  );

  mux4_scan_ctrl #(.HOLD(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_valid(in_valid3),
    .in_ready(in_ready3), .mux_i(mux_i3), .mux_s(mux_s3), .mux_y(mux_y3),
    .ser_bit(ser_bit3), .ser_valid(ser_valid3), .ser_last(ser_last3),
    .err(err3), .err_clr(err_clr3), .word_cnt(word_cnt3)
  );

  always @(negedge clk) begin
    if (ser_valid1 === 1'b1) obs1.push_back('{ser_bit1, ser_last1, cyc});
    if (ser_valid3 === 1'b1) obs3.push_back('{ser_bit3, ser_last3, cyc});
  end

  // Offer a word, wait for acceptance, and queue the four expected bits.
  task automatic send(input bit d3, input logic [3:0] w, input bit keep,
                      output int unsigned xc);
    int unsigned h;
    h = d3 ? 3 : 1;
    if (d3) begin in_data3 = w; in_valid3 = 1'b1; end
    else    begin in_data1 = w; in_valid1 = 1'b1; end
    for (int k = 0; k < 200; k++) begin
      if ((d3 ? in_ready3 : in_ready1) === 1'b1) break;
      @(negedge clk);
    end
    xc = cyc;
    for (int i = 0; i < 4; i++) begin
      ev_t e;
      e.b = (fault && !d3) ? 1'b0 : w[i];
      e.l = (i == 3);
      e.c = xc + 1 + (i + 1) * h;
      if (d3) exp3.push_back(e);
      else    exp1.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    if (!keep) begin
      if (d3) in_valid3 = 1'b0;
      else    in_valid1 = 1'b0;
    end
  endtask

  task automatic wait_drain(input bit d3);
    for (int k = 0; k < 300; k++) begin
      if (d3 ? (obs3.size() >= exp3.size()) : (obs1.size() >= exp1.size())) break;
      @(negedge clk);
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests++;
    if (in_ready1 !== 1'b1) begin
      fails++; $display("FAIL reset_ready1 got %b want 1", in_ready1);
    end
    tests++;
    if ({mux_i1, mux_s1, ser_bit1, ser_valid1, ser_last1, err1, word_cnt1} !== 18'd0) begin
      fails++; $display("FAIL reset_outs1 got %h want 0",
                        {mux_i1, mux_s1, ser_bit1, ser_valid1, ser_last1, err1, word_cnt1});
    end
    tests++;
    if (in_ready3 !== 1'b1) begin
      fails++; $display("FAIL reset_ready3 got %b want 1", in_ready3);
    end
    tests++;
    if ({mux_i3, mux_s3, ser_bit3, ser_valid3, ser_last3, err3, word_cnt3} !== 18'd0) begin
      fails++; $display("FAIL reset_outs3 got %h want 0",
                        {mux_i3, mux_s3, ser_bit3, ser_valid3, ser_last3, err3, word_cnt3});
    end
  endtask

  task automatic test_hold1();
    int unsigned xc;
    rst_n = 1'b1;
    send(1'b0, 4'b1011, 1'b0, xc);
    tests++;
    if (in_ready1 !== 1'b0 || mux_i1 !== 4'b1011 || mux_s1 !== 2'd0) begin
      fails++; $display("FAIL hold1_load got rdy=%b i=%b s=%0d want rdy=0 i=1011 s=0",
                        in_ready1, mux_i1, mux_s1);
    end
    wait_drain(1'b0);
    while (exp1.size() > 0) begin
      ev_t e, o;
      e = exp1.pop_front();
      if (obs1.size() > 0) o = obs1.pop_front();
      else o = '{1'bx, 1'bx, 0};
      tests++;
      if (o !== e) begin
        fails++; $display("FAIL hold1_bit got b=%b l=%b c=%0d want b=%b l=%b c=%0d",
                          o.b, o.l, o.c, e.b, e.l, e.c);
      end
    end
    tests++;
    if (obs1.size() != 0) begin
      fails++; $display("FAIL hold1_extra got %0d extra bits want 0", obs1.size());
      obs1.delete();
    end
    tests++;
    if (word_cnt1 !== 8'd1 || err1 !== 1'b0) begin
      fails++; $display("FAIL hold1_cnt_err got cnt=%0d err=%b want cnt=1 err=0", word_cnt1, err1);
    end
    tests++;
    if (ser_bit1 !== 1'b1 || ser_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin
      fails++; $display("FAIL hold1_idle got bit=%b v=%b rdy=%b want bit=1 v=0 rdy=1",
                        ser_bit1, ser_valid1, in_ready1);
    end
  endtask

  task automatic test_hold3();
    int unsigned xc;
    send(1'b1, 4'b0110, 1'b0, xc);
    for (int k = 0; k < 12; k++) begin
      tests++;
      if (mux_s3 !== 2'(k / 3)) begin
        fails++; $display("FAIL hold3_mux_s k=%0d got %0d want %0d", k, mux_s3, k / 3);
      end
      @(negedge clk);
    end
    wait_drain(1'b1);
    while (exp3.size() > 0) begin
      ev_t e, o;
      e = exp3.pop_front();
      if (obs3.size() > 0) o = obs3.pop_front();
      else o = '{1'bx, 1'bx, 0};
      tests++;
      if (o !== e) begin
        fails++; $display("FAIL hold3_bit got b=%b l=%b c=%0d want b=%b l=%b c=%0d",
                          o.b, o.l, o.c, e.b, e.l, e.c);
      end
    end
    tests++;
    if (obs3.size() != 0 || word_cnt3 !== 8'd1 || err3 !== 1'b0) begin
      fails++; $display("FAIL hold3_end got extra=%0d cnt=%0d err=%b want 0/1/0",
                        obs3.size(), word_cnt3, err3);
      obs3.delete();
    end
  endtask

  task automatic test_back_to_back();
    int unsigned xa, xb;
    send(1'b0, 4'b0001, 1'b1, xa);
    in_data1 = 4'b1110;
    @(negedge clk);
    tests++;
    if (mux_i1 !== 4'b0001 || in_ready1 !== 1'b0) begin
      fails++; $display("FAIL b2b_hold got i=%b rdy=%b want i=0001 rdy=0", mux_i1, in_ready1);
    end
    send(1'b0, 4'b1110, 1'b0, xb);
    tests++;
    if ((xb - xa) !== 5) begin
      fails++; $display("FAIL b2b_gap got %0d want 5", xb - xa);
    end
    wait_drain(1'b0);
    while (exp1.size() > 0) begin
      ev_t e, o;
      e = exp1.pop_front();
      if (obs1.size() > 0) o = obs1.pop_front();
      else o = '{1'bx, 1'bx, 0};
      tests++;
      if (o !== e) begin
        fails++; $display("FAIL b2b_bit got b=%b l=%b c=%0d want b=%b l=%b c=%0d",
                          o.b, o.l, o.c, e.b, e.l, e.c);
      end
    end
    tests++;
    if (obs1.size() != 0 || word_cnt1 !== 8'd3) begin
      fails++; $display("FAIL b2b_end got extra=%0d cnt=%0d want 0/3", obs1.size(), word_cnt1);
      obs1.delete();
    end
  endtask

  task automatic test_err();
    int unsigned xc;
    fault = 1'b1;
    send(1'b0, 4'b1111, 1'b0, xc);
    tests++;
    if (err1 !== 1'b0) begin
      fails++; $display("FAIL err_before got %b want 0", err1);
    end
    @(negedge clk);
    tests++;
    if (err1 !== 1'b1) begin
      fails++; $display("FAIL err_set got %b want 1", err1);
    end
    err_clr1 = 1'b1;
    @(negedge clk);
    err_clr1 = 1'b0;
    tests++;
    if (err1 !== 1'b1) begin
      fails++; $display("FAIL err_set_wins got %b want 1", err1);
    end
    wait_drain(1'b0);
    fault = 1'b0;
    while (exp1.size() > 0) begin
      ev_t e, o;
      e = exp1.pop_front();
      if (obs1.size() > 0) o = obs1.pop_front();
      else o = '{1'bx, 1'bx, 0};
      tests++;
      if (o !== e) begin
        fails++; $display("FAIL err_bit got b=%b l=%b c=%0d want b=%b l=%b c=%0d",
                          o.b, o.l, o.c, e.b, e.l, e.c);
      end
    end
    tests++;
    if (err1 !== 1'b1 || word_cnt1 !== 8'd4) begin
      fails++; $display("FAIL err_sticky got err=%b cnt=%0d want 1/4", err1, word_cnt1);
    end
    err_clr1 = 1'b1;
    @(negedge clk);
    err_clr1 = 1'b0;
    tests++;
    if (err1 !== 1'b0) begin
      fails++; $display("FAIL err_clear got %b want 0", err1);
    end
  endtask

  task automatic test_reset_mid();
    int unsigned xc;
    send(1'b0, 4'b1010, 1'b0, xc);
    repeat (3) void'(exp1.pop_back());
    @(negedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    tests++;
    if (in_ready1 !== 1'b1 ||
        {mux_i1, mux_s1, ser_bit1, ser_valid1, ser_last1, err1, word_cnt1} !== 18'd0) begin
      fails++; $display("FAIL rstmid_outs got rdy=%b vec=%h want rdy=1 vec=0", in_ready1,
                        {mux_i1, mux_s1, ser_bit1, ser_valid1, ser_last1, err1, word_cnt1});
    end
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    wait_drain(1'b0);
    while (exp1.size() > 0) begin
      ev_t e, o;
      e = exp1.pop_front();
      if (obs1.size() > 0) o = obs1.pop_front();
      else o = '{1'bx, 1'bx, 0};
      tests++;
      if (o !== e) begin
        fails++; $display("FAIL rstmid_bit got b=%b l=%b c=%0d want b=%b l=%b c=%0d",
                          o.b, o.l, o.c, e.b, e.l, e.c);
      end
    end
    tests++;
    if (obs1.size() != 0 || word_cnt1 !== 8'd0 || in_ready1 !== 1'b1) begin
      fails++; $display("FAIL rstmid_end got extra=%0d cnt=%0d rdy=%b want 0/0/1",
                        obs1.size(), word_cnt1, in_ready1);
      obs1.delete();
    end
    obs3.delete();
  endtask

  task automatic test_wrap();
    int unsigned xc;
    for (int n = 0; n < 255; n++) send(1'b0, 4'($urandom), 1'b1, xc);
    in_valid1 = 1'b0;
    wait_drain(1'b0);
    tests++;
    if (word_cnt1 !== 8'd255) begin
      fails++; $display("FAIL wrap_255 got %0d want 255", word_cnt1);
    end
    send(1'b0, 4'($urandom), 1'b0, xc);
    wait_drain(1'b0);
    tests++;
    if (word_cnt1 !== 8'd0) begin
      fails++; $display("FAIL wrap_0 got %0d want 0", word_cnt1);
    end
    while (exp1.size() > 0) begin
      ev_t e, o;
      e = exp1.pop_front();
      if (obs1.size() > 0) o = obs1.pop_front();
      else o = '{1'bx, 1'bx, 0};
      tests++;
      if (o !== e) begin
        fails++; $display("FAIL wrap_bit got b=%b l=%b c=%0d want b=%b l=%b c=%0d",
                          o.b, o.l, o.c, e.b, e.l, e.c);
      end
    end
    tests++;
    if (obs1.size() != 0 || err1 !== 1'b0) begin
      fails++; $display("FAIL wrap_end got extra=%0d err=%b want 0/0", obs1.size(), err1);
    end
  endtask

  initial begin
    test_reset();
    test_hold1();
    test_hold3();
    test_back_to_back();
    test_err();
    test_reset_mid();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mux4_scan_ctrl.md
MUX4_SCAN_CTRL -- requirements
Module: mux4_scan_ctrl

Interface
REQ-001 Parameter HOLD, default 1, meaning: number of clk cycles each select value is held before mux_y is sampled (legal range 1..16).
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_data  input  4  parallel word to be scanned through the 4:1 mux.
REQ-005 in_valid  input  1  in_data is valid this cycle.
REQ-006 in_ready  output  1  block can accept a word this cycle.
REQ-007 mux_i  output  4  data bus driven to the downstream 4:1 mux data inputs.
REQ-008 mux_s  output  2  select driven to the 4:1 mux.
REQ-009 mux_y  input  1  4:1 mux output, combinational from mux_i/mux_s.
REQ-010 ser_bit  output  1  serialized bit sampled from mux_y.
REQ-011 ser_valid  output  1  one-cycle pulse qualifying ser_bit.
REQ-012 ser_last  output  1  high with ser_valid on the 4th bit of a word.
REQ-013 err  output  1  sticky flag: a sampled mux_y differed from the expected bit.
REQ-014 err_clr  input  1  synchronous clear of err.
REQ-015 word_cnt  output  8  count of completed words, wraps 255->0.

Function
REQ-016 FSM states IDLE and SCAN only; in_ready SHALL be 1 exactly when state is IDLE.
REQ-017 Handshake: transfer when in_valid && in_ready; in IDLE, in_valid low -> stay IDLE, outputs held.
REQ-018 On transfer: next cycle mux_i = in_data (held word), mux_s = 0, hold counter = 0, state = SCAN.
REQ-019 In SCAN, hold counter increments each cycle; when it equals HOLD-1, mux_y is sampled, counter returns to 0, and mux_s increments.
REQ-020 Sampled value appears on ser_bit with ser_valid = 1 the cycle after sampling; ser_bit holds its value otherwise; ser_valid is 0 otherwise.
REQ-021 Bit order: mux_s 0,1,2,3, so a correct mux emits in_data[0] first, in_data[3] last.
REQ-022 At the sample with mux_s = 3: state -> IDLE, ser_last = 1 together with that ser_valid, word_cnt increments (mod 256), and mux_s wraps to 0.
REQ-023 Per-word occupancy is 4*HOLD cycles in SCAN; new word acceptable the cycle ser_valid/ser_last of the previous word is high (in_ready already 1).
REQ-024 mux_i SHALL remain stable for the entire SCAN; changes only on a transfer.
REQ-025 Check: at each sample, if mux_y != held_word[mux_s], err is set next cycle.
REQ-026 err_clr and a mismatch in the same cycle: set wins (err stays 1).
REQ-027 in_valid while in SCAN is ignored (no transfer, no data loss on the held word).
REQ-028 HOLD outside 1..16 is an elaboration error.

Reset
REQ-029 While rst_n = 0: state IDLE, in_ready 1, mux_i 0, mux_s 0, ser_bit 0, ser_valid 0, ser_last 0, err 0, word_cnt 0, hold counter 0.
REQ-030 Reset asserted mid-SCAN aborts the word immediately; no ser_valid for it; word_cnt not incremented.
REQ-031 First transfer possible on the first rising edge after rst_n deasserts.

Structure
REQ-032 Shared package holds state encoding (IDLE = 0, SCAN = 1) and MUX_W = 4, SEL_W = 2 constants.
REQ-033 One sub-module is natural: mux4_hold_timer (hold counter with terminal-count pulse, parameter HOLD).
REQ-034 The 4:1 mux is external; the bench connects the existing structural mux between mux_i/mux_s and mux_y.

Verification
REQ-035 HOLD=1, reset release, send 4'b1011 -> ser_bit sequence 1,1,0,1 on cycles 2..5 after transfer, ser_last on 4th, word_cnt = 1, err = 0.
REQ-036 HOLD=3, send 4'b0110 -> mux_s steps every 3 cycles, ser_valid pulses spaced 3 cycles, bits 0,1,1,0.
REQ-037 Back-to-back 4'b0001 then 4'b1110 with in_valid held high -> second transfer on ser_last cycle, 8 bits 1,0,0,0,0,1,1,1, no gap beyond HOLD.
REQ-038 Faulted mux (mux_y forced 0), send 4'b1111 -> err = 1 after first sample; err_clr pulse -> err 0 only when no mismatch in that cycle.
REQ-039 rst_n low for 1 cycle during 2nd bit of 4'b1010 -> all outputs at reset values, no ser_last, word_cnt unchanged at 0.
REQ-040 256 words sent -> word_cnt wraps to 0.
